// File: rtl/div_pkg.sv
// Shared state encoding, counter sizing and operand magnitude helper for the
// signed long divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int MAX_WIDTH = 64;
  // Sized for the widest legal operand so one counter type serves every WIDTH.
  localparam int CNT_W = $clog2(MAX_WIDTH);

  // Callers sign-extend narrower operands to MAX_WIDTH before the call.
  function automatic logic [MAX_WIDTH-1:0] abs_op(input logic [MAX_WIDTH-1:0] x);
    return x[MAX_WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so the kept value always
  // fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, dvs};
    q_bit   = (shifted >= {1'b0, dvs});
    rem_out = WIDTH'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/signed_long_divider.sv
// Multi-cycle restoring divider with signed/unsigned mode and truncating sign
// fixup. Define DIV_ZERO_CHECK_EN to short-circuit division by zero.
module signed_long_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero_err,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             ns_q, ns_d;
  logic             ds_q, ds_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
`ifdef DIV_ZERO_CHECK_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // The dividend shifts out of the top of dq while quotient bits enter below.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dq_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    ns_d        = ns_q;
    ds_d        = ds_q;
    ovf_pend_d  = ovf_pend_q;
    q_out_d     = q_out_q;
    r_out_d     = r_out_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    dz_d        = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          dq_d       = signed_mode ? WIDTH'(abs_op(MAX_WIDTH'($signed(N)))) : N;
          dvs_d      = signed_mode ? WIDTH'(abs_op(MAX_WIDTH'($signed(D)))) : D;
          ns_d       = N[WIDTH-1] & signed_mode;
          ds_d       = D[WIDTH-1] & signed_mode;
          ovf_pend_d = signed_mode && (N == MIN_VAL) && (D == '1);
          rem_d      = '0;
          cnt_d      = CNT_W'(WIDTH - 1);
          state_d    = CALC;
`ifdef DIV_ZERO_CHECK_EN
          if (D == '0) begin
            q_out_d = '1;
            r_out_d = N;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        q_out_d = (ns_q ^ ds_q) ? -dq_q : dq_q;
        r_out_d = ns_q ? -rem_q : rem_q;
        ovf_d   = ovf_pend_q;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = 1'b0;
`endif
        state_d = DONE;
      end
      DONE: begin
        // Results land on DONE entry; valid follows one cycle later.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      ns_q        <= 1'b0;
      ds_q        <= 1'b0;
      ovf_pend_q  <= 1'b0;
      q_out_q     <= '0;
      r_out_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      ns_q        <= ns_d;
      ds_q        <= ds_d;
      ovf_pend_q  <= ovf_pend_d;
      q_out_q     <= q_out_d;
      r_out_q     <= r_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q        <= dz_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_out_q;
  assign R         = r_out_q;
  assign ovf       = ovf_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div_zero_err = dz_q;
`else
  assign div_zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_signed_long_divider.sv
// Directed, table-driven bench for signed_long_divider at WIDTH = 32, plus
// hand sequences for backpressure and mid-operation reset.
module tb_signed_long_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        signed_mode = 1'b0;
  logic [31:0] N = '0;
  logic [31:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_zero_err;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  signed_long_divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .signed_mode  (signed_mode),
    .N            (N),
    .D            (D),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Q            (Q),
    .R            (R),
    .div_zero_err (div_zero_err),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic        sm;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents one operation, scrambles the inputs after
  // accept and returns cycles from the accept edge until out_valid.
  task automatic issue(input logic [31:0] n, input logic [31:0] d, input logic sm,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    N = n; D = d; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; N = 32'hA5A5_A5A5; D = 32'h3; signed_mode = ~sm;
    check("busy_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_lat;
    int stale;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0};
    vecs[6]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        DZ_EN, 1'b0};
    vecs[7]  = '{32'hFFFFFFFB, 32'd0,        1'b1, DZ_EN ? 32'hFFFFFFFF : 32'd1,
                 32'hFFFFFFFB, DZ_EN, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};
    vecs[9]  = '{32'd7,        32'd100,      1'b0, 32'd0,        32'd7,        1'b0, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[12] = '{32'h80000000, 32'd2,        1'b1, 32'hC0000000, 32'd0,        1'b0, 1'b0};
    vecs[13] = '{32'hDEADBEEF, 32'h10,       1'b0, 32'h0DEADBEE, 32'hF,        1'b0, 1'b0};

    // Reset state while reset is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_div_zero_err", div_zero_err, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
    $display("reset: in_ready=%0d out_valid=%0d Q=%h R=%h", in_ready, out_valid, Q, R);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].n, vecs[i].d, vecs[i].sm, lat);
      exp_lat = (DZ_EN && vecs[i].d == 32'd0) ? 1 : 34;
      $display("op %0d: N=%h D=%h sm=%0d -> Q=%h R=%h dz=%0d ovf=%0d lat=%0d",
               i, vecs[i].n, vecs[i].d, vecs[i].sm, Q, R, div_zero_err, ovf, lat);
      check($sformatf("vec%0d_latency", i), lat, exp_lat);
      check($sformatf("vec%0d_Q", i), Q, vecs[i].q);
      check($sformatf("vec%0d_R", i), R, vecs[i].r);
      check($sformatf("vec%0d_div_zero_err", i), div_zero_err, vecs[i].dz);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
      take();
    end

    // Backpressure: DONE holds for 10 cycles, then a back-to-back issue.
    issue(32'd1000, 32'd3, 1'b0, lat);
    check("bp_latency", lat, 34);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_Q", Q, 333);
      check("bp_hold_R", R, 1);
      check("bp_hold_in_ready", in_ready, 0);
    end
    take();
    $display("bp: 1000/3 held 10 cycles -> Q=%h R=%h, after take out_valid=%0d in_ready=%0d",
             32'd333, 32'd1, out_valid, in_ready);
    check("bp_taken_valid", out_valid, 0);
    check("bp_taken_in_ready", in_ready, 1);
    issue(32'd9, 32'd4, 1'b0, lat);
    $display("b2b: 9/4 -> Q=%h R=%h lat=%0d", Q, R, lat);
    check("b2b_latency", lat, 34);
    check("b2b_Q", Q, 2);
    check("b2b_R", R, 1);
    take();

    // Reset during CALC cycle 15 must discard the operation.
    N = 32'd1000; D = 32'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_Q", Q, 0);
    check("midrst_R", R, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale_valid", stale, 0);
    issue(32'd9, 32'd4, 1'b0, lat);
    $display("post-reset: 9/4 -> Q=%h R=%h lat=%0d", Q, R, lat);
    check("postrst_latency", lat, 34);
    check("postrst_Q", Q, 2);
    check("postrst_R", R, 1);
    take();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
